// File: rtl/sipp_control_unit_pkg.sv
// Shared definitions for the SIPP control unit: opcodes, FSM state encodings,
// instruction field slices and datapath select constants.
package sipp_control_unit_pkg;

  // Opcode values held in ir[15:12]
  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_LOADC = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_JMPZ  = 4'h5;

  // FSM state encodings (also exported on the debug state port)
  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_LOAD   = 4'd3,
    ST_STORE  = 4'd4,
    ST_ADD    = 4'd5,
    ST_LOADC  = 4'd6,
    ST_SUB    = 4'd7,
    ST_JMPZ   = 4'd8,
    ST_JMP    = 4'd9,
    ST_HALT   = 4'd10
  } state_e;

  // ALU function select
  localparam logic [1:0] ALU_FN_ADD   = 2'd0;
  localparam logic [1:0] ALU_FN_SUBTR = 2'd1;
  localparam logic [1:0] ALU_FN_PASS  = 2'd2;

  // Register file write-data source
  localparam logic [1:0] RF_W_DATA_SEL_ALU = 2'd0;
  localparam logic [1:0] RF_W_DATA_SEL_MEM = 2'd1;
  localparam logic [1:0] RF_W_DATA_SEL_IR  = 2'd2;

  // Register file P-port address source
  localparam logic RF_RP_ADDR_SEL_A = 1'b0;
  localparam logic RF_RP_ADDR_SEL_B = 1'b1;

  // Instruction field slices
  function automatic logic [3:0] ir_opcode(input logic [15:0] ir_v);
    return ir_v[15:12];
  endfunction

  function automatic logic [3:0] ir_reg_a(input logic [15:0] ir_v);
    return ir_v[11:8];
  endfunction

  function automatic logic [3:0] ir_reg_b(input logic [15:0] ir_v);
    return ir_v[7:4];
  endfunction

  function automatic logic [3:0] ir_reg_c(input logic [15:0] ir_v);
    return ir_v[3:0];
  endfunction

  function automatic logic [7:0] ir_mem_addr(input logic [15:0] ir_v);
    return ir_v[7:0];
  endfunction

  function automatic logic [7:0] ir_constant(input logic [15:0] ir_v);
    return ir_v[7:0];
  endfunction

  function automatic logic [7:0] ir_offset(input logic [15:0] ir_v);
    return ir_v[7:0];
  endfunction

endpackage

// File: rtl/sipp_control_unit.sv
// SIPP control unit: Moore FSM that sequences fetch/decode/execute and drives
// every datapath control strobe. Outputs decode the state register only;
// while reset is held low they are forced to the INIT values so no write can
// slip through in a reset cycle.
module sipp_control_unit
  import sipp_control_unit_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        rf_p_zero,
  output logic        i_rd,
  output logic        ir_ld,
  output logic        pc_clr,
  output logic        pc_inc,
  output logic        pc_ld,
  output logic        d_rd,
  output logic        d_wr,
  output logic        rf_w_wr,
  output logic        rf_p_rd,
  output logic        rf_q_rd,
  output logic        rf_p_addr_sel,
  output logic [1:0]  rf_w_data_sel,
  output logic [1:0]  alu_s,
  output logic        halted,
  output logic [3:0]  state
);

  state_e     state_q;
  state_e     state_d;
  logic [3:0] opcode_s;
  logic       unused_ir_bits;

  assign opcode_s       = ir_opcode(ir);
  assign unused_ir_bits = ^ir[11:0];
  assign state          = state_q;

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unused encodings recover to INIT
  always_comb begin
    state_d = ST_INIT;
    case (state_q)
      ST_INIT:   state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode_s)
          OP_LOAD:  state_d = ST_LOAD;
          OP_STORE: state_d = ST_STORE;
          OP_ADD:   state_d = ST_ADD;
          OP_LOADC: state_d = ST_LOADC;
          OP_SUB:   state_d = ST_SUB;
          OP_JMPZ:  state_d = ST_JMPZ;
          default:  state_d = HALT_ON_ILLEGAL ? ST_HALT : ST_FETCH;
        endcase
      end
      ST_LOAD:   state_d = ST_FETCH;
      ST_STORE:  state_d = ST_FETCH;
      ST_ADD:    state_d = ST_FETCH;
      ST_LOADC:  state_d = ST_FETCH;
      ST_SUB:    state_d = ST_FETCH;
      ST_JMPZ: begin
        if (rf_p_zero) begin
          state_d = ST_JMP;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_JMP:    state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_INIT;
    endcase
  end

  // Output decode of the state register, overridden to INIT values in reset
  always_comb begin
    i_rd          = 1'b0;
    ir_ld         = 1'b0;
    pc_clr        = 1'b0;
    pc_inc        = 1'b0;
    pc_ld         = 1'b0;
    d_rd          = 1'b0;
    d_wr          = 1'b0;
    rf_w_wr       = 1'b0;
    rf_p_rd       = 1'b0;
    rf_q_rd       = 1'b0;
    rf_p_addr_sel = RF_RP_ADDR_SEL_A;
    rf_w_data_sel = RF_W_DATA_SEL_ALU;
    alu_s         = ALU_FN_ADD;
    halted        = 1'b0;
    if (!rst) begin
      pc_clr = 1'b1;
    end else begin
      case (state_q)
        ST_INIT: pc_clr = 1'b1;
        ST_FETCH: begin
          i_rd   = 1'b1;
          ir_ld  = 1'b1;
          pc_inc = 1'b1;
        end
        ST_DECODE: halted = 1'b0;
        ST_LOAD: begin
          d_rd          = 1'b1;
          rf_w_data_sel = RF_W_DATA_SEL_MEM;
          rf_w_wr       = 1'b1;
        end
        ST_STORE: begin
          rf_p_rd       = 1'b1;
          rf_p_addr_sel = RF_RP_ADDR_SEL_A;
          d_wr          = 1'b1;
        end
        ST_ADD, ST_SUB: begin
          rf_p_rd       = 1'b1;
          rf_p_addr_sel = RF_RP_ADDR_SEL_B;
          rf_q_rd       = 1'b1;
          alu_s         = (state_q == ST_SUB) ? ALU_FN_SUBTR : ALU_FN_ADD;
          rf_w_data_sel = RF_W_DATA_SEL_ALU;
          rf_w_wr       = 1'b1;
        end
        ST_LOADC: begin
          rf_w_data_sel = RF_W_DATA_SEL_IR;
          rf_w_wr       = 1'b1;
        end
        ST_JMPZ: begin
          rf_p_rd       = 1'b1;
          rf_p_addr_sel = RF_RP_ADDR_SEL_A;
        end
        ST_JMP:  pc_ld  = 1'b1;
        ST_HALT: halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

endmodule

// File: doc/sipp_control_unit.md
Name: sipp_control_unit

Overview:
Control FSM for the Six-Instruction Programmable Processor. It is the other end of the datapath control interface. It consumes the datapath's ir and rf_p_zero outputs and drives every datapath control strobe: fetch, register file, memory, ALU and PC. It also owns the instruction-memory read strobe and a sticky halt indication.

Parameters:
HALT_ON_ILLEGAL, 1, 1: an undefined opcode enters HALT; 0: an undefined opcode is a NOP that returns to FETCH.

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  reset, synchronous, active-low
ir  in  16  instruction register from datapath; opcode ir[15:12], REG_A ir[11:8], REG_B ir[7:4], REG_C ir[3:0], addr/const/offset ir[7:0]
rf_p_zero  in  1  datapath P-port read data == 0
i_rd  out  1  instruction memory read
ir_ld  out  1  load ir
pc_clr  out  1  clear pc
pc_inc  out  1  pc <= pc+1
pc_ld  out  1  pc <= pc+offset-1
d_rd  out  1  data memory read
d_wr  out  1  data memory write
rf_w_wr  out  1  register file write (address REG_A)
rf_p_rd  out  1  P-port read enable
rf_q_rd  out  1  Q-port read enable (address REG_C)
rf_p_addr_sel  out  1  0 = REG_A, 1 = REG_B
rf_w_data_sel  out  2  0 = ALU, 1 = MEM, 2 = IR constant
alu_s  out  2  0 = ADD, 1 = SUBTR, 2 = PASS
halted  out  1  high while in HALT
state  out  4  current state encoding, for debug

Behaviour:
- Moore FSM. All outputs are combinational decodes of the state register. Any output not listed for a state is 0 (selects default 0).
- States and encoding: INIT 0, FETCH 1, DECODE 2, LOAD 3, STORE 4, ADD 5, LOADC 6, SUB 7, JMPZ 8, JMP 9, HALT 10. Encodings 11-15 go to INIT on the next edge.
- Reset:
  - rst==0 at posedge -> state INIT.
  - While rst==0, outputs are forced to INIT values combinationally: pc_clr=1, all others 0, halted=0. No memory or register write can occur in a reset cycle.
- INIT: pc_clr=1 -> FETCH.
- FETCH: i_rd=1, ir_ld=1, pc_inc=1 -> DECODE.
- DECODE: no strobes. Next state by ir[15:12]:
  - 0000 -> LOAD
  - 0001 -> STORE
  - 0010 -> ADD
  - 0011 -> LOADC
  - 0100 -> SUB
  - 0101 -> JMPZ
  - other -> HALT if HALT_ON_ILLEGAL, else FETCH
- LOAD: d_rd=1, rf_w_data_sel=1, rf_w_wr=1 -> FETCH. Memory read is combinational within the cycle.
- STORE: rf_p_rd=1, rf_p_addr_sel=0, d_wr=1 -> FETCH.
- ADD: rf_p_rd=1, rf_p_addr_sel=1, rf_q_rd=1, alu_s=0, rf_w_data_sel=0, rf_w_wr=1 -> FETCH.
- SUB: same as ADD but alu_s=1.
- LOADC: rf_w_data_sel=2, rf_w_wr=1 -> FETCH.
- JMPZ: rf_p_rd=1, rf_p_addr_sel=0. Next state is JMP if rf_p_zero, else FETCH. rf_p_zero is sampled at the posedge ending JMPZ.
- JMP: pc_ld=1 -> FETCH. The offset is 8-bit and applied by the datapath; the -1 compensates for the FETCH increment.
- HALT: all strobes 0, halted=1. Stays in HALT until rst==0.
- Latency:
  - LOAD, STORE, ADD, SUB, LOADC and untaken JMPZ each take 3 cycles (FETCH, DECODE, exec).
  - Taken JMPZ takes 4 cycles.
- Invariants:
  - ir_ld is asserted only in FETCH.
  - At most one of pc_clr, pc_inc, pc_ld is asserted in any cycle.
  - d_rd and d_wr are never asserted together.

Decomposition:
- Shared defines header, extending the existing SIPP defines:
  - opcode values
  - state encodings
  - ir field slices (REG_A, REG_B, REG_C, MEM_ADDR, CONSTANT, OFFSET)
  - ALU_FN_*, RF_W_DATA_SEL_*, RF_RP_ADDR_SEL_* constants
- Single module; no sub-module. A top-level sipp wrapper joins it to the datapath.

Test Plan:
- Reset then release: rst=0 for 2 cycles -> state=0, pc_clr=1, all other strobes 0. First cycle after release: state=0 (INIT). Next cycle: state=1 with i_rd=ir_ld=pc_inc=1.
- ir=16'h3105 (LOADC r1,5) after FETCH -> DECODE, then LOADC cycle with rf_w_wr=1, rf_w_data_sel=2, then FETCH. 3 cycles total.
- ir=16'h2123 (ADD r1,r2,r3) -> ADD cycle: rf_p_addr_sel=1, rf_p_rd=rf_q_rd=1, alu_s=0, rf_w_data_sel=0, rf_w_wr=1. Same with ir=16'h4123 -> alu_s=1.
- ir=16'h0210 then 16'h1210 -> LOAD cycle d_rd=1, rf_w_data_sel=1, rf_w_wr=1; STORE cycle d_wr=1, rf_p_rd=1, rf_p_addr_sel=0, d_rd=0.
- ir=16'h51FC (JMPZ r1,-4): rf_p_zero=1 -> JMP state with pc_ld=1, then FETCH (4 cycles). rf_p_zero=0 -> FETCH directly (3 cycles).
- ir=16'hF000: HALT_ON_ILLEGAL=1 -> halted=1 and state=10 for 20 cycles with no strobes, then rst=0 -> INIT. HALT_ON_ILLEGAL=0 -> FETCH after DECODE. rst=0 asserted during the ADD cycle -> rf_w_wr=0 that cycle.
